// File: rtl/mem_access.sv
// Memory-access pipeline stage: data-memory req/ready sequencing, load extension,
// store lane steering, branch resolution and the MEM/WB pipeline register.
module mem_access (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] mem_pc,
   input  logic [31:0] target_pc,
   input  logic [31:0] reg_pc,
   input  logic        mem_isbranch,
   input  logic        mem_isjump,
   input  logic        mem_memread,
   input  logic        mem_memwrite,
   input  logic        mem_regwrite,
   input  logic [1:0]  mem_memtoreg,
   input  logic        mem_zero,
   input  logic [31:0] mem_aluresult,
   input  logic [31:0] mem_rs2_data,
   input  logic [2:0]  mem_funct3,
   input  logic [4:0]  mem_rd,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        pcsrc,
   output logic [31:0] branch_target,
   output logic        mem_stall,
   output logic        misalign,
   output logic        wb_regwrite,
   output logic [1:0]  wb_memtoreg,
   output logic [31:0] wb_aluresult,
   output logic [31:0] wb_readdata,
   output logic [31:0] wb_reg_pc,
   output logic [4:0]  wb_rd,
   output logic        fsm_state
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
   state_t state;

   logic        access;
   logic        aligned_access;
   logic        taken;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;
   logic [31:0] store_wdata;
   logic [3:0]  store_strb;

   assign fsm_state      = state;
   assign access         = mem_memread | mem_memwrite;
   assign aligned_access = access & ~misalign;

   // Handshake: a transfer completes in any cycle where dmem_req and dmem_ready are
   // both high; req stays high with stable addr/we/wdata/wstrb until then, and ready
   // seen while req is low means nothing. Reset drops req immediately.
   assign dmem_req      = aligned_access & reset;
   assign dmem_we       = dmem_req & mem_memwrite;
   assign dmem_addr     = {mem_aluresult[31:2], 2'b00};
   assign dmem_wdata    = store_wdata;
   assign dmem_wstrb    = dmem_we ? store_strb : 4'b0000;
   assign mem_stall     = aligned_access & ~(dmem_req & dmem_ready);
   assign branch_target = target_pc;
   assign pcsrc         = mem_isjump | (mem_isbranch & taken);

   always_comb begin
      misalign = 1'b0;
      if (access) begin
         if (mem_funct3[1:0] == 2'b01)
            misalign = mem_aluresult[0];
         else if (mem_funct3[1:0] == 2'b10)
            misalign = (mem_aluresult[1:0] != 2'b00);
      end
   end

   // BEQ/BNE come from a SUB, the ordered compares from SLT/SLTU (zero = not less).
   always_comb begin
      taken = 1'b0;
      case (mem_funct3)
         3'b001, 3'b100, 3'b110: taken = ~mem_zero;
         3'b000, 3'b101, 3'b111: taken = mem_zero;
         default:                taken = 1'b0;
      endcase
   end

   always_comb begin
      ld_byte = dmem_rdata[7:0];
      case (mem_aluresult[1:0])
         2'b00: ld_byte = dmem_rdata[7:0];
         2'b01: ld_byte = dmem_rdata[15:8];
         2'b10: ld_byte = dmem_rdata[23:16];
         2'b11: ld_byte = dmem_rdata[31:24];
         default: ld_byte = dmem_rdata[7:0];
      endcase
      ld_half = mem_aluresult[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (mem_funct3)
         3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_data = {24'd0, ld_byte};
         3'b101:  load_data = {16'd0, ld_half};
         default: load_data = dmem_rdata;
      endcase
   end

   always_comb begin
      case (mem_funct3[1:0])
         2'b00: begin
            store_wdata = {4{mem_rs2_data[7:0]}};
            store_strb  = 4'b0001 << mem_aluresult[1:0];
         end
         2'b01: begin
            store_wdata = {2{mem_rs2_data[15:0]}};
            store_strb  = 4'b0011 << mem_aluresult[1:0];
         end
         default: begin
            store_wdata = mem_rs2_data;
            store_strb  = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         wb_regwrite  <= 1'b0;
         wb_memtoreg  <= 2'b00;
         wb_aluresult <= 32'd0;
         wb_readdata  <= 32'd0;
         wb_reg_pc    <= 32'd0;
         wb_rd        <= 5'd0;
      end else begin
         case (state)
            IDLE:    state <= (dmem_req && !dmem_ready) ? WAIT : IDLE;
            WAIT:    state <= (dmem_req && !dmem_ready) ? WAIT : IDLE;
            default: state <= IDLE;
         endcase
         if (mem_stall) begin
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 2'b00;
            wb_aluresult <= 32'd0;
            wb_readdata  <= 32'd0;
            wb_reg_pc    <= 32'd0;
            wb_rd        <= 5'd0;
         end else begin
            wb_regwrite  <= mem_regwrite & ~misalign;
            wb_memtoreg  <= mem_memtoreg;
            wb_aluresult <= mem_aluresult;
            wb_readdata  <= mem_memread ? load_data : 32'd0;
            wb_reg_pc    <= reg_pc;
            wb_rd        <= mem_rd;
         end
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, wait-state and reset sequences,
// then randomized instructions checked against a behavioural model.
module tb_mem_access;

   logic        clock;
   logic        reset;
   logic [31:0] mem_pc, target_pc, reg_pc;
   logic        mem_isbranch, mem_isjump, mem_memread, mem_memwrite, mem_regwrite;
   logic [1:0]  mem_memtoreg;
   logic        mem_zero;
   logic [31:0] mem_aluresult, mem_rs2_data;
   logic [2:0]  mem_funct3;
   logic [4:0]  mem_rd;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;
   logic        pcsrc, mem_stall, misalign;
   logic [31:0] branch_target;
   logic        wb_regwrite;
   logic [1:0]  wb_memtoreg;
   logic [31:0] wb_aluresult, wb_readdata, wb_reg_pc;
   logic [4:0]  wb_rd;
   logic        fsm_state;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        memread, memwrite, isbranch, isjump, regwrite, zero;
      logic [2:0]  f3;
      logic [31:0] addr, rs2, rdata, reg_pc, target_pc;
      logic [4:0]  rd;
      logic [1:0]  memtoreg;
      logic        exp_req, exp_we, exp_misalign, exp_pcsrc, exp_wb_regwrite;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_wdata, exp_readdata;
   } vec_t;

   vec_t vecs[$];

   mem_access dut (
      .clock(clock), .reset(reset),
      .mem_pc(mem_pc), .target_pc(target_pc), .reg_pc(reg_pc),
      .mem_isbranch(mem_isbranch), .mem_isjump(mem_isjump),
      .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
      .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
      .mem_zero(mem_zero), .mem_aluresult(mem_aluresult),
      .mem_rs2_data(mem_rs2_data), .mem_funct3(mem_funct3), .mem_rd(mem_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .pcsrc(pcsrc), .branch_target(branch_target), .mem_stall(mem_stall),
      .misalign(misalign), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
      .wb_aluresult(wb_aluresult), .wb_readdata(wb_readdata),
      .wb_reg_pc(wb_reg_pc), .wb_rd(wb_rd), .fsm_state(fsm_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rd_, input logic wr, input logic br, input logic jp,
                               input logic rw, input logic [2:0] f3, input logic zero,
                               input logic [31:0] addr, input logic [31:0] rs2,
                               input logic [31:0] rdata);
      vec_t v;
      v.memread = rd_; v.memwrite = wr; v.isbranch = br; v.isjump = jp;
      v.regwrite = rw; v.f3 = f3; v.zero = zero; v.addr = addr; v.rs2 = rs2;
      v.rdata = rdata;
      v.rd = 5'($urandom_range(1, 31));
      v.memtoreg = 2'($urandom_range(0, 3));
      v.reg_pc = $urandom;
      v.target_pc = $urandom;
      v.exp_req = 0; v.exp_we = 0; v.exp_misalign = 0; v.exp_pcsrc = 0;
      v.exp_wb_regwrite = 0; v.exp_wstrb = 0; v.exp_wdata = 0; v.exp_readdata = 0;
      return v;
   endfunction

   function automatic vec_t ex(input vec_t v, input logic req, input logic we,
                               input logic [3:0] strb, input logic [31:0] wdata,
                               input logic mis, input logic pc, input logic wbrw,
                               input logic [31:0] rdd);
      vec_t r = v;
      r.exp_req = req; r.exp_we = we; r.exp_wstrb = strb; r.exp_wdata = wdata;
      r.exp_misalign = mis; r.exp_pcsrc = pc; r.exp_wb_regwrite = wbrw;
      r.exp_readdata = rdd;
      return r;
   endfunction

   // Reference model: computed from the ISA meaning of each field.
   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [2:0] f3);
      int off = int'(addr % 4);
      logic [31:0] b = (rdata >> (8 * off)) & 32'hFF;
      logic [31:0] h = (rdata >> (8 * off)) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? b - 32'd256 : b;
         3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return rdata;
      endcase
   endfunction

   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int size = (v.f3[1:0] == 0) ? 1 : (v.f3[1:0] == 1) ? 2 : 4;
      int off = int'(v.addr % 4);
      logic acc = v.memread | v.memwrite;
      logic mis = acc && ((v.addr % size) != 0);
      logic less, taken;
      r.exp_misalign = mis;
      r.exp_req = acc && !mis;
      r.exp_we = r.exp_req && v.memwrite;
      r.exp_wstrb = 0;
      r.exp_wdata = 0;
      if (r.exp_we) begin
         if (size == 1) begin
            r.exp_wdata = (v.rs2 & 32'hFF) * 32'h01010101;
            r.exp_wstrb = 4'(1 << off);
         end else if (size == 2) begin
            r.exp_wdata = (v.rs2 & 32'hFFFF) * 32'h00010001;
            r.exp_wstrb = 4'(3 << off);
         end else begin
            r.exp_wdata = v.rs2;
            r.exp_wstrb = 4'hF;
         end
      end
      less = !v.zero;
      case (v.f3)
         3'd0: taken = v.zero;
         3'd1: taken = !v.zero;
         3'd4, 3'd6: taken = less;
         3'd5, 3'd7: taken = !less;
         default: taken = 0;
      endcase
      r.exp_pcsrc = v.isjump || (v.isbranch && taken);
      r.exp_wb_regwrite = v.regwrite && !mis;
      r.exp_readdata = v.memread ? model_load(v.rdata, v.addr, v.f3) : 32'd0;
      return r;
   endfunction

   // driver: present one EX/MEM instruction, hold it through `waits` not-ready cycles
   task automatic apply_vec(input vec_t v, input int waits, input string tag);
      int w = v.exp_req ? waits : 0;
      logic [31:0] exp_rdd;
      mem_pc = $urandom; target_pc = v.target_pc; reg_pc = v.reg_pc;
      mem_isbranch = v.isbranch; mem_isjump = v.isjump;
      mem_memread = v.memread; mem_memwrite = v.memwrite; mem_regwrite = v.regwrite;
      mem_memtoreg = v.memtoreg; mem_zero = v.zero; mem_aluresult = v.addr;
      mem_rs2_data = v.rs2; mem_funct3 = v.f3; mem_rd = v.rd;
      dmem_ready = (w == 0);
      dmem_rdata = (w == 0) ? v.rdata : $urandom;
      exp_q.push_back(v.exp_readdata);
      for (int i = 0; i < w; i++) begin
         #1;
         check({tag, " stall_wait"}, 32'(mem_stall), 32'd1);
         check({tag, " req_wait"}, 32'(dmem_req), 32'd1);
         check({tag, " addr_wait"}, dmem_addr, {v.addr[31:2], 2'b00});
         @(posedge clock); @(negedge clock);
         check({tag, " bubble_regwrite"}, 32'(wb_regwrite), 32'd0);
         check({tag, " bubble_rd"}, 32'(wb_rd), 32'd0);
         check({tag, " state_wait"}, 32'(fsm_state), 32'd1);
         if (i == w - 1) begin
            dmem_ready = 1'b1;
            dmem_rdata = v.rdata;
         end
      end
      #1;
      check({tag, " req"}, 32'(dmem_req), 32'(v.exp_req));
      check({tag, " we"}, 32'(dmem_we), 32'(v.exp_we));
      check({tag, " wstrb"}, 32'(dmem_wstrb), 32'(v.exp_wstrb));
      if (v.exp_we) check({tag, " wdata"}, dmem_wdata, v.exp_wdata);
      if (v.exp_req) check({tag, " addr"}, dmem_addr, {v.addr[31:2], 2'b00});
      check({tag, " stall"}, 32'(mem_stall), 32'd0);
      check({tag, " misalign"}, 32'(misalign), 32'(v.exp_misalign));
      check({tag, " pcsrc"}, 32'(pcsrc), 32'(v.exp_pcsrc));
      check({tag, " target"}, branch_target, v.target_pc);
      @(posedge clock); @(negedge clock);
      exp_rdd = exp_q.pop_front();
      check({tag, " wb_regwrite"}, 32'(wb_regwrite), 32'(v.exp_wb_regwrite));
      check({tag, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
      check({tag, " wb_memtoreg"}, 32'(wb_memtoreg), 32'(v.memtoreg));
      check({tag, " wb_aluresult"}, wb_aluresult, v.addr);
      check({tag, " wb_reg_pc"}, wb_reg_pc, v.reg_pc);
      if (!(v.memread && v.exp_misalign)) check({tag, " wb_readdata"}, wb_readdata, exp_rdd);
      check({tag, " state_idle"}, 32'(fsm_state), 32'd0);
   endtask

   task automatic clear_inputs();
      mem_pc = 0; target_pc = 0; reg_pc = 0; mem_isbranch = 0; mem_isjump = 0;
      mem_memread = 0; mem_memwrite = 0; mem_regwrite = 0; mem_memtoreg = 0;
      mem_zero = 0; mem_aluresult = 0; mem_rs2_data = 0; mem_funct3 = 0; mem_rd = 0;
      dmem_ready = 0; dmem_rdata = 0;
   endtask

   initial begin
      vec_t v;
      // directed vector table: mk(rd,wr,br,jp,rw,f3,zero,addr,rs2,rdata) then expectations
      vecs.push_back(ex(mk(0,1,0,0,0,3'd0,0,32'h103,32'h000000A5,0), 1,1,4'b1000,32'hA5A5A5A5,0,0,0,32'h0));
      vecs.push_back(ex(mk(1,0,0,0,1,3'd0,0,32'h103,0,32'hA5000000), 1,0,4'b0000,0,0,0,1,32'hFFFFFFA5));
      vecs.push_back(ex(mk(1,0,0,0,1,3'd4,0,32'h103,0,32'hA5000000), 1,0,4'b0000,0,0,0,1,32'h000000A5));
      vecs.push_back(ex(mk(1,0,0,0,1,3'd0,0,32'h101,0,32'h00007F00), 1,0,4'b0000,0,0,0,1,32'h0000007F));
      vecs.push_back(ex(mk(1,0,0,0,1,3'd1,0,32'h102,0,32'h80011234), 1,0,4'b0000,0,0,0,1,32'hFFFF8001));
      vecs.push_back(ex(mk(1,0,0,0,1,3'd5,0,32'h100,0,32'h80011234), 1,0,4'b0000,0,0,0,1,32'h00001234));
      vecs.push_back(ex(mk(1,0,0,0,1,3'd2,0,32'h204,0,32'hDEADBEEF), 1,0,4'b0000,0,0,0,1,32'hDEADBEEF));
      vecs.push_back(ex(mk(0,1,0,0,0,3'd1,0,32'h102,32'h1234ABCD,0), 1,1,4'b1100,32'hABCDABCD,0,0,0,32'h0));
      vecs.push_back(ex(mk(0,1,0,0,0,3'd2,0,32'h108,32'hCAFEF00D,0), 1,1,4'b1111,32'hCAFEF00D,0,0,0,32'h0));
      vecs.push_back(ex(mk(1,0,0,0,1,3'd2,0,32'h202,0,0), 0,0,4'b0000,0,1,0,0,32'h0));
      vecs.push_back(ex(mk(0,1,0,0,0,3'd1,0,32'h201,32'h5555,0), 0,0,4'b0000,0,1,0,0,32'h0));
      vecs.push_back(ex(mk(1,0,0,0,1,3'd1,0,32'h103,0,0), 0,0,4'b0000,0,1,0,0,32'h0));
      vecs.push_back(ex(mk(0,0,1,0,0,3'd1,0,32'h0,0,0), 0,0,4'b0000,0,0,1,0,32'h0));
      vecs.push_back(ex(mk(0,0,1,0,0,3'd0,0,32'h5,0,0), 0,0,4'b0000,0,0,0,0,32'h0));
      vecs.push_back(ex(mk(0,0,1,0,0,3'd5,1,32'h0,0,0), 0,0,4'b0000,0,0,1,0,32'h0));
      vecs.push_back(ex(mk(0,0,0,1,1,3'd0,0,32'h44,0,0), 0,0,4'b0000,0,0,1,1,32'h0));

      clear_inputs();
      reset = 1'b0;
      @(negedge clock); @(negedge clock);
      check("rst wb_regwrite", 32'(wb_regwrite), 32'd0);
      check("rst wb_rd", 32'(wb_rd), 32'd0);
      check("rst wb_aluresult", wb_aluresult, 32'd0);
      check("rst wb_readdata", wb_readdata, 32'd0);
      check("rst wb_reg_pc", wb_reg_pc, 32'd0);
      check("rst wb_memtoreg", 32'(wb_memtoreg), 32'd0);
      check("rst req", 32'(dmem_req), 32'd0);
      check("rst wstrb", 32'(dmem_wstrb), 32'd0);
      check("rst state", 32'(fsm_state), 32'd0);
      reset = 1'b1;
      @(negedge clock);

      foreach (vecs[i]) apply_vec(vecs[i], 0, $sformatf("vec%0d", i));

      // LW 0x200: ready low for the request cycle plus three WAIT cycles
      v = ex(mk(1,0,0,0,1,3'd2,0,32'h200,0,32'h13579BDF), 1,0,4'b0000,0,0,0,1,32'h13579BDF);
      apply_vec(v, 4, "lw_wait");
      v = ex(mk(0,1,0,0,0,3'd0,0,32'h306,32'h7E,0), 1,1,4'b0100,32'h7E7E7E7E,0,0,0,32'h0);
      apply_vec(v, 2, "sb_wait");

      // reset asserted while waiting on memory
      clear_inputs();
      mem_memread = 1; mem_regwrite = 1; mem_funct3 = 3'd2; mem_aluresult = 32'h300;
      mem_rd = 5'd9; reg_pc = 32'h1234;
      @(posedge clock); @(negedge clock);
      check("rstwait state_wait", 32'(fsm_state), 32'd1);
      check("rstwait req_before", 32'(dmem_req), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("rstwait req_dropped", 32'(dmem_req), 32'd0);
      check("rstwait state_idle", 32'(fsm_state), 32'd0);
      check("rstwait wb_regwrite", 32'(wb_regwrite), 32'd0);
      check("rstwait wb_rd", 32'(wb_rd), 32'd0);
      check("rstwait wb_reg_pc", wb_reg_pc, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      v = ex(mk(1,0,0,0,1,3'd2,0,32'h300,0,32'h0BADF00D), 1,0,4'b0000,0,0,0,1,32'h0BADF00D);
      apply_vec(v, 0, "post_rst_lw");

      // randomized instructions against the model
      for (int n = 0; n < 80; n++) begin
         int k = $urandom_range(0, 4);
         logic [2:0] f3;
         logic [31:0] addr = $urandom;
         if (k == 0) begin
            case ($urandom_range(0, 4))
               0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
            endcase
            v = mk(1,0,0,0,1,f3,1'($urandom),addr,$urandom,$urandom);
         end else if (k == 1) begin
            f3 = 3'($urandom_range(0, 2));
            v = mk(0,1,0,0,0,f3,1'($urandom),addr,$urandom,$urandom);
         end else if (k == 2) begin
            case ($urandom_range(0, 5))
               0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd4; 3: f3 = 3'd5; 4: f3 = 3'd6; default: f3 = 3'd7;
            endcase
            v = mk(0,0,1,0,0,f3,1'($urandom),addr,$urandom,$urandom);
         end else if (k == 3) begin
            v = mk(0,0,0,1,1,3'($urandom),1'($urandom),addr,$urandom,$urandom);
         end else begin
            v = mk(0,0,0,0,1,3'($urandom),1'($urandom),addr,$urandom,$urandom);
         end
         apply_vec(model(v), $urandom_range(0, 2), $sformatf("rand%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
